// File: rtl/rv32_e_fpu_divsqrt_if.sv
// Issue/response bundle between the execute stage and the FDIV.S/FSQRT.S unit,
// plus the ALU control codes that select the operation.
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 5
`endif
`ifndef ALU_FDIV
`define ALU_FDIV (`ALU_CONTROL_WIDTH'(12))
`endif
`ifndef ALU_FSQRT
`define ALU_FSQRT (`ALU_CONTROL_WIDTH'(13))
`endif

interface rv32_e_fpu_divsqrt_if;
    logic                          start_i;
    logic                          flush_i;
    logic [`ALU_CONTROL_WIDTH-1:0] fpu_control_i;
    logic [31:0]                   src_a_i;
    logic [31:0]                   src_b_i;
    logic                          busy_o;
    logic                          valid_o;
    logic [31:0]                   result_o;
    logic [4:0]                    flags_o;

    modport master (
        output start_i, flush_i, fpu_control_i, src_a_i, src_b_i,
        input  busy_o, valid_o, result_o, flags_o
    );

    modport slave (
        input  start_i, flush_i, fpu_control_i, src_a_i, src_b_i,
        output busy_o, valid_o, result_o, flags_o
    );
endinterface

// File: rtl/rv32_e_fpu_divsqrt.sv
// Multi-cycle binary32 divide / square root: restoring digit recurrence, RNE rounding,
// DAZ inputs, flush-to-zero outputs, RISC-V fflags {NV,DZ,OF,UF,NX}.
module rv32_e_fpu_divsqrt #(
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rv32_e_fpu_divsqrt_if.slave   bus
);
    localparam int          N    = 26 / ITER_PER_CYCLE;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_e;

    state_e             state_q, state_d;
    logic               is_sqrt_q, is_sqrt_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [23:0]        dvs_q, dvs_d;
    logic [28:0]        rem_q, rem_d;
    logic [51:0]        rad_q, rad_d;
    logic [25:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        res_q, res_d;
    logic [4:0]         flg_q, flg_d;

    // Operand classification straight off the bus (subnormals count as zero)
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic        op_div, op_sqrt, accept, q_sign;

    assign ea      = bus.src_a_i[30:23];
    assign eb      = bus.src_b_i[30:23];
    assign fa      = bus.src_a_i[22:0];
    assign fb      = bus.src_b_i[22:0];
    assign a_zero  = (ea == 8'h00);
    assign b_zero  = (eb == 8'h00);
    assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);
    assign a_snan  = a_nan && !fa[22];
    assign b_snan  = b_nan && !fb[22];
    assign q_sign  = bus.src_a_i[31] ^ bus.src_b_i[31];
    assign op_div  = (bus.fpu_control_i == `ALU_FDIV);
    assign op_sqrt = (bus.fpu_control_i == `ALU_FSQRT);
    assign accept  = bus.start_i && !bus.flush_i && (state_q == S_IDLE) && (op_div || op_sqrt);

    logic        spec_hit;
    logic [31:0] spec_res;
    logic [4:0]  spec_flg;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (that would infer a latch).
    always_comb begin
        spec_hit = 1'b1;
        spec_res = 32'd0;
        spec_flg = 5'd0;
        if (op_sqrt) begin
            if (a_nan) begin
                spec_res = QNAN;
                spec_flg = {a_snan, 4'b0000};
            end else if (a_zero) begin
                spec_res = {bus.src_a_i[31], 31'd0};
            end else if (bus.src_a_i[31]) begin
                spec_res = QNAN;
                spec_flg = 5'b10000;
            end else if (a_inf) begin
                spec_res = 32'h7F80_0000;
            end else begin
                spec_hit = 1'b0;
            end
        end else begin
            if (a_nan || b_nan) begin
                spec_res = QNAN;
                spec_flg = {a_snan || b_snan, 4'b0000};
            end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                spec_res = QNAN;
                spec_flg = 5'b10000;
            end else if (b_zero) begin
                spec_res = {q_sign, 8'hFF, 23'd0};
                spec_flg = 5'b01000;
            end else if (a_inf) begin
                spec_res = {q_sign, 8'hFF, 23'd0};
            end else if (a_zero || b_inf) begin
                spec_res = {q_sign, 31'd0};
            end else begin
                spec_hit = 1'b0;
            end
        end
    end

    // Unpacking of the registered operands during PREP
    logic [23:0]       ma, mb;
    logic signed [9:0] div_exp, sq_e, sq_exp;
    logic [24:0]       sq_mant;

    always_comb begin
        ma      = {1'b1, a_q[22:0]};
        mb      = {1'b1, b_q[22:0]};
        div_exp = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
        sq_e    = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        sq_mant = {1'b0, ma};
        if (sq_e[0]) begin
            sq_e    = sq_e - 10'sd1;
            sq_mant = {ma, 1'b0};
        end
        sq_exp  = (sq_e >>> 1) + 10'sd127;
    end

    // One ITER cycle: ITER_PER_CYCLE restoring steps chained combinationally
    logic [28:0] st_rem, st_trial;
    logic [25:0] st_quo;
    logic [51:0] st_rad;

    always_comb begin
        st_rem   = rem_q;
        st_quo   = quo_q;
        st_rad   = rad_q;
        st_trial = 29'd0;
        for (int i = 0; i < ITER_PER_CYCLE; i++) begin
            if (is_sqrt_q) begin
                st_rem   = {st_rem[26:0], st_rad[51:50]};
                st_rad   = {st_rad[49:0], 2'b00};
                st_trial = {1'b0, st_quo, 2'b01};
            end else begin
                st_trial = {5'd0, dvs_q};
            end
            if (st_rem >= st_trial) begin
                st_rem = st_rem - st_trial;
                st_quo = {st_quo[24:0], 1'b1};
            end else begin
                st_quo = {st_quo[24:0], 1'b0};
            end
            if (!is_sqrt_q) st_rem = {st_rem[27:0], 1'b0};
        end
    end

    // ROUND: normalise, round-half-even, then overflow / flush-to-zero
    logic [25:0]       norm;
    logic signed [9:0] nexp, rexp;
    logic              g, r, s, inc;
    logic [24:0]       sum;
    logic [31:0]       rnd_res;
    logic [4:0]        rnd_flg;

    always_comb begin
        norm = quo_q[25] ? quo_q : {quo_q[24:0], 1'b0};
        nexp = quo_q[25] ? exp_q : exp_q - 10'sd1;
        g    = norm[1];
        r    = norm[0];
        s    = (rem_q != 29'd0);
        inc  = g && (r || s || norm[2]);
        sum  = {1'b0, norm[25:2]} + {24'd0, inc};
        rexp = nexp + $signed({9'd0, sum[24]});
        if (rexp >= 10'sd255) begin
            rnd_res = {sign_q, 8'hFF, 23'd0};
            rnd_flg = 5'b00101;
        end else if (rexp <= 10'sd0) begin
            rnd_res = {sign_q, 31'd0};
            rnd_flg = 5'b00011;
        end else begin
            rnd_res = {sign_q, rexp[7:0], sum[22:0]};
            rnd_flg = {4'b0000, g | r | s};
        end
    end

    always_comb begin
        state_d   = state_q;
        is_sqrt_d = is_sqrt_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        rad_d     = rad_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        flg_d     = flg_q;
        case (state_q)
            S_IDLE: if (accept) begin
                is_sqrt_d = op_sqrt;
                a_d       = bus.src_a_i;
                b_d       = bus.src_b_i;
                if (spec_hit) begin
                    res_d   = spec_res;
                    flg_d   = spec_flg;
                    state_d = S_DONE;
                end else begin
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                quo_d   = 26'd0;
                cnt_d   = 5'(N - 1);
                dvs_d   = mb;
                if (is_sqrt_q) begin
                    sign_d = 1'b0;
                    exp_d  = sq_exp;
                    rem_d  = 29'd0;
                    rad_d  = {sq_mant, 27'd0};
                end else begin
                    sign_d = a_q[31] ^ b_q[31];
                    exp_d  = div_exp;
                    rem_d  = {5'd0, ma};
                    rad_d  = 52'd0;
                end
                state_d = S_ITER;
            end
            S_ITER: begin
                rem_d = st_rem;
                quo_d = st_quo;
                rad_d = st_rad;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = S_ROUND;
            end
            S_ROUND: begin
                res_d   = rnd_res;
                flg_d   = rnd_flg;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A flush abandons the op without touching the architectural result
        if (bus.flush_i) begin
            state_d = S_IDLE;
            res_d   = res_q;
            flg_d   = flg_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; combinational blocks above use blocking ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            is_sqrt_q <= 1'b0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            sign_q    <= 1'b0;
            exp_q     <= 10'sd0;
            dvs_q     <= 24'd0;
            rem_q     <= 29'd0;
            rad_q     <= 52'd0;
            quo_q     <= 26'd0;
            cnt_q     <= 5'd0;
            res_q     <= 32'd0;
            flg_q     <= 5'd0;
        end else begin
            state_q   <= state_d;
            is_sqrt_q <= is_sqrt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            rad_q     <= rad_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            flg_q     <= flg_d;
        end
    end

    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.valid_o  = (state_q == S_DONE);
    assign bus.result_o = res_q;
    assign bus.flags_o  = flg_q;
endmodule

// File: tb/tb_rv32_e_fpu_divsqrt.sv
// Directed bench for rv32_e_fpu_divsqrt: arithmetic results, flags, latency,
// flush, ignored issues and asynchronous reset.
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 5
`endif
`ifndef ALU_FDIV
`define ALU_FDIV (`ALU_CONTROL_WIDTH'(12))
`endif
`ifndef ALU_FSQRT
`define ALU_FSQRT (`ALU_CONTROL_WIDTH'(13))
`endif

module tb_rv32_e_fpu_divsqrt;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rv32_e_fpu_divsqrt_if bus ();

    rv32_e_fpu_divsqrt #(.ITER_PER_CYCLE(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [`ALU_CONTROL_WIDTH-1:0] FDIV  = `ALU_FDIV;
    localparam logic [`ALU_CONTROL_WIDTH-1:0] FSQRT = `ALU_FSQRT;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [`ALU_CONTROL_WIDTH-1:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [4:0] exp_flg,
                          input int exp_lat);
        int cyc;
        bus.fpu_control_i = ctrl;
        bus.src_a_i       = a;
        bus.src_b_i       = b;
        bus.start_i       = 1'b1;
        tick();
        bus.start_i = 1'b0;
        cyc = 1;
        while (bus.valid_o !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " result"}, bus.result_o, exp_res);
        check({tag, " flags"}, {27'd0, bus.flags_o}, {27'd0, exp_flg});
        check({tag, " busy@valid"}, {31'd0, bus.busy_o}, 32'd1);
        tick();
        check({tag, " idle"}, {30'd0, bus.busy_o, bus.valid_o}, 32'd0);
    endtask

    initial begin
        int cyc;
        int vcount;
        rst               = 1'b1;
        bus.start_i       = 1'b0;
        bus.flush_i       = 1'b0;
        bus.fpu_control_i = '0;
        bus.src_a_i       = 32'd0;
        bus.src_b_i       = 32'd0;
        tick();
        tick();
        check("reset busy", {31'd0, bus.busy_o}, 32'd0);
        check("reset valid", {31'd0, bus.valid_o}, 32'd0);
        check("reset result", bus.result_o, 32'd0);
        check("reset flags", {27'd0, bus.flags_o}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("div 6/2",      FDIV,  32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29);
        run_op("div 1/3",      FDIV,  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29);
        run_op("div -6/2",     FDIV,  32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 29);
        run_op("sqrt 2",       FSQRT, 32'h40000000, 32'h00000000, 32'h3FB504F3, 5'b00001, 29);
        run_op("sqrt 4",       FSQRT, 32'h40800000, 32'h12345678, 32'h40000000, 5'b00000, 29);
        run_op("div overflow", FDIV,  32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 29);
        run_op("div underflw", FDIV,  32'h80800000, 32'h40000000, 32'h80000000, 5'b00011, 29);
        run_op("div 1/0",      FDIV,  32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
        run_op("div 0/0",      FDIV,  32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000, 1);
        run_op("div snan",     FDIV,  32'h7FA00000, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);
        run_op("div qnan/0",   FDIV,  32'h7FC00000, 32'h00000000, 32'h7FC00000, 5'b00000, 1);
        run_op("div daz",      FDIV,  32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1);
        run_op("sqrt -0",      FSQRT, 32'h80000000, 32'h00000000, 32'h80000000, 5'b00000, 1);
        run_op("sqrt -1",      FSQRT, 32'hBF800000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);

        // Flush in cycle 10 of an FDIV
        bus.fpu_control_i = FDIV;
        bus.src_a_i       = 32'h40C00000;
        bus.src_b_i       = 32'h40000000;
        bus.start_i       = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (9) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("flush busy", {31'd0, bus.busy_o}, 32'd0);
        check("flush result kept", bus.result_o, 32'h7FC00000);
        check("flush flags kept", {27'd0, bus.flags_o}, 32'h10);
        vcount = 0;
        repeat (35) begin
            tick();
            if (bus.valid_o === 1'b1) vcount++;
        end
        check("flush no valid", vcount, 32'd0);

        // Flush beats start in IDLE; unknown control codes are ignored
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        check("flush+start busy", {31'd0, bus.busy_o}, 32'd0);
        bus.fpu_control_i = '0;
        bus.start_i       = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("bad ctrl busy", {31'd0, bus.busy_o}, 32'd0);

        run_op("post-flush sqrt 4", FSQRT, 32'h40800000, 32'h00000000, 32'h40000000, 5'b00000, 29);

        // Start held high with new operands while busy
        bus.fpu_control_i = FDIV;
        bus.src_a_i       = 32'h40C00000;
        bus.src_b_i       = 32'h40000000;
        bus.start_i       = 1'b1;
        tick();
        bus.src_a_i       = 32'h3F800000;
        bus.src_b_i       = 32'h40400000;
        bus.fpu_control_i = FSQRT;
        cyc = 1;
        while (bus.valid_o !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        bus.start_i = 1'b0;
        check("held start latency", cyc, 32'd29);
        check("held start result", bus.result_o, 32'h40400000);
        check("held start flags", {27'd0, bus.flags_o}, 32'd0);
        tick();
        check("held start idle", {31'd0, bus.busy_o}, 32'd0);

        // Asynchronous reset in the middle of ITER
        bus.fpu_control_i = FDIV;
        bus.src_a_i       = 32'h3F800000;
        bus.src_b_i       = 32'h40400000;
        bus.start_i       = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (10) tick();
        check("pre-reset busy", {31'd0, bus.busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("async rst busy", {31'd0, bus.busy_o}, 32'd0);
        check("async rst valid", {31'd0, bus.valid_o}, 32'd0);
        check("async rst result", bus.result_o, 32'd0);
        check("async rst flags", {27'd0, bus.flags_o}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        run_op("post-reset 1/3", FDIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
